alu: RTL and testbench

- Execute-stage arithmetic/logic unit for the 32-bit DLX-style pipeline.
- Selects operand B between the forwarded register value and the sign-extended immediate through an internal 2:1 n-bit operand mux (mux_2to1_n, n = WIDTH).
- Computes one of 16 operations selected by a 4-bit control code.
- Presents the result combinationally and also through a stall-aware output register.

---
 rtl/alu.sv | 128 ++++++++++++
 tb/tb_alu.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module  : alu (with mux_2to1_n operand selector)
// Brief   : DLX execute-stage ALU, 16 ops, combinational and stall-aware
//           registered result/overflow outputs.
// Revision: 1.0 - initial release
// ============================================================================

module mux_2to1_n #(
    parameter int N = 32
) (
    input  logic         i_sel,
    input  logic [N-1:0] i_d0,
    input  logic [N-1:0] i_d1,
    output logic [N-1:0] o_y
);
    assign o_y = i_sel ? i_d1 : i_d0;
endmodule

module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [WIDTH-1:0] bus_a,
    input  logic [WIDTH-1:0] bus_b,
    input  logic [WIDTH-1:0] imm32,
    input  logic             alu_src,
    input  logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_out,
    output logic             overflow,
    output logic [WIDTH-1:0] alu_out_q,
    output logic             overflow_q
);
    localparam int c_SHAMT_W = $clog2(WIDTH);

    localparam logic [3:0] c_ADD  = 4'b0000;
    localparam logic [3:0] c_ADDU = 4'b0001;
    localparam logic [3:0] c_SUB  = 4'b0010;
    localparam logic [3:0] c_SUBU = 4'b0011;
    localparam logic [3:0] c_AND  = 4'b0100;
    localparam logic [3:0] c_OR   = 4'b0101;
    localparam logic [3:0] c_XOR  = 4'b0110;
    localparam logic [3:0] c_SLL  = 4'b0111;
    localparam logic [3:0] c_SRL  = 4'b1000;
    localparam logic [3:0] c_SRA  = 4'b1001;
    localparam logic [3:0] c_SEQ  = 4'b1010;
    localparam logic [3:0] c_SNE  = 4'b1011;
    localparam logic [3:0] c_SLT  = 4'b1100;
    localparam logic [3:0] c_SGT  = 4'b1101;
    localparam logic [3:0] c_SLE  = 4'b1110;
    localparam logic [3:0] c_SGE  = 4'b1111;

    logic [WIDTH-1:0]     w_b;
    logic [WIDTH-1:0]     w_sum;
    logic [WIDTH-1:0]     w_diff;
    logic [c_SHAMT_W-1:0] w_shamt;
    logic                 w_lt;
    logic                 w_eq;
    logic                 w_add_ov;
    logic                 w_sub_ov;
    logic [WIDTH-1:0]     w_res;
    logic                 w_ov;

    mux_2to1_n #(.N(WIDTH)) u_opb_mux (
        .i_sel (alu_src),
        .i_d0  (bus_b),
        .i_d1  (imm32),
        .o_y   (w_b)
    );

    assign w_sum   = bus_a + w_b;
    assign w_diff  = bus_a - w_b;
    assign w_shamt = w_b[c_SHAMT_W-1:0];
    assign w_lt    = $signed(bus_a) < $signed(w_b);
    assign w_eq    = (bus_a == w_b);

    // Signed overflow: operand signs agree (ADD) or differ (SUB) and the
    // result sign departs from A.
    assign w_add_ov = (bus_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1]  != bus_a[WIDTH-1]);
    assign w_sub_ov = (bus_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != bus_a[WIDTH-1]);

    always_comb begin
        w_res = '0;
        w_ov  = 1'b0;
        case (alu_ctrl)
            c_ADD:  begin w_res = w_sum;  w_ov = w_add_ov; end
            c_ADDU: w_res = w_sum;
            c_SUB:  begin w_res = w_diff; w_ov = w_sub_ov; end
            c_SUBU: w_res = w_diff;
            c_AND:  w_res = bus_a & w_b;
            c_OR:   w_res = bus_a | w_b;
            c_XOR:  w_res = bus_a ^ w_b;
            c_SLL:  w_res = bus_a << w_shamt;
            c_SRL:  w_res = bus_a >> w_shamt;
            c_SRA:  w_res = $unsigned($signed(bus_a) >>> w_shamt);
            c_SEQ:  w_res = {{(WIDTH-1){1'b0}}, w_eq};
            c_SNE:  w_res = {{(WIDTH-1){1'b0}}, ~w_eq};
            c_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_lt};
            c_SGT:  w_res = {{(WIDTH-1){1'b0}}, ~w_lt & ~w_eq};
            c_SLE:  w_res = {{(WIDTH-1){1'b0}}, w_lt | w_eq};
            c_SGE:  w_res = {{(WIDTH-1){1'b0}}, ~w_lt};
            default: begin w_res = '0; w_ov = 1'b0; end
        endcase
    end

    assign alu_out  = w_res;
    assign overflow = w_ov;

    logic [WIDTH-1:0] r_out;
    logic             r_ov;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
            r_ov  <= 1'b0;
        end else if (!stall) begin
            r_out <= w_res;
            r_ov  <= w_ov;
        end
    end

    assign alu_out_q  = r_out;
    assign overflow_q = r_ov;
endmodule

`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu
// Brief   : Scoreboard bench for alu using directed, hand-computed vectors.
// Revision: 1.0 - initial release
// ============================================================================

module tb_alu;
    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] bus_a;
    logic [31:0] bus_b;
    logic [31:0] imm32;
    logic        alu_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic        overflow;
    logic [31:0] alu_out_q;
    logic        overflow_q;

    alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .bus_a      (bus_a),
        .bus_b      (bus_b),
        .imm32      (imm32),
        .alu_src    (alu_src),
        .alu_ctrl   (alu_ctrl),
        .alu_out    (alu_out),
        .overflow   (overflow),
        .alu_out_q  (alu_out_q),
        .overflow_q (overflow_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        is_reg;
        logic [31:0] val;
        logic        ov;
    } exp_t;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Monitor: pops each expectation as soon as it is posted and compares
    // against the corresponding DUT output pair.
    initial begin
        exp_t        e;
        logic [31:0] act_v;
        logic        act_o;
        forever begin
            wait (q_exp.size() != 0);
            e = q_exp.pop_front();
            act_v = e.is_reg ? alu_out_q  : alu_out;
            act_o = e.is_reg ? overflow_q : overflow;
            n_checks++;
            if (act_v !== e.val || act_o !== e.ov) begin
                n_errors++;
                $display("FAIL %s: got val=%h ov=%b, expected val=%h ov=%b",
                         e.name, act_v, act_o, e.val, e.ov);
            end
        end
    end

    task automatic apply(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic src,
                         input logic [3:0] ctrl);
        bus_a    = a;
        bus_b    = b;
        imm32    = imm;
        alu_src  = src;
        alu_ctrl = ctrl;
    endtask

    task automatic expect_comb(input string name, input logic [31:0] v, input logic o);
        exp_t e;
        #1;
        e.name = name; e.is_reg = 1'b0; e.val = v; e.ov = o;
        q_exp.push_back(e);
        #1;
    endtask

    task automatic expect_reg(input string name, input logic [31:0] v, input logic o);
        exp_t e;
        e.name = name; e.is_reg = 1'b1; e.val = v; e.ov = o;
        q_exp.push_back(e);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        apply(32'h0, 32'h0, 32'h0, 1'b0, 4'b0000);
        #2 reset = 1'b1;
        #1 expect_reg("reset_q", 32'h0, 1'b0);

        // Arithmetic and overflow
        apply(32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 4'b0000); expect_comb("add_ov",  32'h80000000, 1'b1);
        apply(32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 4'b0001); expect_comb("addu",    32'h80000000, 1'b0);
        apply(32'h80000000, 32'hFFFFFFFF, 32'h0, 1'b0, 4'b0000); expect_comb("add_negov", 32'h7FFFFFFF, 1'b1);
        apply(32'h80000000, 32'h1, 32'h0, 1'b0, 4'b0010); expect_comb("sub_ov",  32'h7FFFFFFF, 1'b1);
        apply(32'h5, 32'h7, 32'h0, 1'b0, 4'b0011);        expect_comb("subu",    32'hFFFFFFFE, 1'b0);
        apply(32'h5, 32'h7, 32'h0, 1'b0, 4'b0010);        expect_comb("sub_noov",32'hFFFFFFFE, 1'b0);

        // Operand mux and shifts (imm shamt 4, bus_b shamt 31)
        apply(32'hF0000000, 32'hFFFFFFFF, 32'h24, 1'b1, 4'b1000); expect_comb("srl_imm", 32'h0F000000, 1'b0);
        apply(32'hF0000000, 32'hFFFFFFFF, 32'h24, 1'b1, 4'b1001); expect_comb("sra_imm", 32'hFF000000, 1'b0);
        apply(32'hF0000000, 32'hFFFFFFFF, 32'h24, 1'b1, 4'b0111); expect_comb("sll_imm", 32'h00000000, 1'b0);
        apply(32'hF0000000, 32'hFFFFFFFF, 32'h24, 1'b0, 4'b1000); expect_comb("srl_reg", 32'h00000001, 1'b0);
        apply(32'hF0000000, 32'hFFFFFFFF, 32'h24, 1'b0, 4'b1001); expect_comb("sra_reg", 32'hFFFFFFFF, 1'b0);

        // Set ops, A=-1 B=1
        apply(32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 4'b1100); expect_comb("slt_m1", 32'h1, 1'b0);
        apply(32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 4'b1101); expect_comb("sgt_m1", 32'h0, 1'b0);
        apply(32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 4'b1110); expect_comb("sle_m1", 32'h1, 1'b0);
        apply(32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 4'b1111); expect_comb("sge_m1", 32'h0, 1'b0);
        apply(32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 4'b1010); expect_comb("seq_m1", 32'h0, 1'b0);
        apply(32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 4'b1011); expect_comb("sne_m1", 32'h1, 1'b0);
        // Set ops, A=B=3
        apply(32'h3, 32'h3, 32'h0, 1'b0, 4'b1010); expect_comb("seq_eq", 32'h1, 1'b0);
        apply(32'h3, 32'h3, 32'h0, 1'b0, 4'b1110); expect_comb("sle_eq", 32'h1, 1'b0);
        apply(32'h3, 32'h3, 32'h0, 1'b0, 4'b1111); expect_comb("sge_eq", 32'h1, 1'b0);
        apply(32'h3, 32'h3, 32'h0, 1'b0, 4'b1100); expect_comb("slt_eq", 32'h0, 1'b0);
        apply(32'h3, 32'h3, 32'h0, 1'b0, 4'b1101); expect_comb("sgt_eq", 32'h0, 1'b0);

        // Logic
        apply(32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 1'b0, 4'b0100); expect_comb("and", 32'h00F000F0, 1'b0);
        apply(32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 1'b0, 4'b0101); expect_comb("or",  32'hFFF0FFF0, 1'b0);
        apply(32'hF0F0F0F0, 32'h0FF00FF0, 32'h0, 1'b0, 4'b0110); expect_comb("xor", 32'hFF00FF00, 1'b0);

        // Reset held across an edge keeps the register cleared
        @(posedge clk); #1 expect_reg("reset_hold", 32'h0, 1'b0);

        // Register path
        @(negedge clk);
        reset = 1'b0;
        apply(32'h2, 32'h3, 32'h0, 1'b0, 4'b0000);
        @(posedge clk); #1 expect_reg("q_add5", 32'h5, 1'b0);

        @(negedge clk);
        stall = 1'b1;
        apply(32'hA, 32'h14, 32'h0, 1'b0, 4'b0000);
        expect_comb("comb_during_stall", 32'h1E, 1'b0);
        @(posedge clk); #1 expect_reg("q_stall_hold", 32'h5, 1'b0);
        @(posedge clk); #1 expect_reg("q_stall_hold2", 32'h5, 1'b0);

        @(negedge clk);
        stall = 1'b0;
        @(posedge clk); #1 expect_reg("q_unstall", 32'h1E, 1'b0);

        @(negedge clk);
        apply(32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 4'b0000);
        @(posedge clk); #1 expect_reg("q_ov", 32'h80000000, 1'b1);

        // Asynchronous reset between edges, priority over stall
        @(negedge clk);
        stall = 1'b1;
        #1 reset = 1'b1;
        #1 expect_reg("q_async_reset", 32'h0, 1'b0);
        @(posedge clk); #1 expect_reg("q_reset_over_stall", 32'h0, 1'b0);

        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        apply(32'h4, 32'h3, 32'h0, 1'b0, 4'b0010);
        #1 expect_reg("q_post_reset_pre_edge", 32'h0, 1'b0);
        @(posedge clk); #1 expect_reg("q_first_capture", 32'h1, 1'b0);

        repeat (10) if (q_exp.size() != 0) #1;
        if (q_exp.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q_exp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
